// File: rtl/motor_emf_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : motor_emf_multi
// Brief    : Multi-channel back-EMF estimator, bemf = K*cur_cmd - R*cur_fb,
//            one shared registered 16x16 multiplier, atomic result update.
//            Optional macro MOTOR_EMF_SAT_EN clamps negative results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module motor_emf_multi #(
    parameter int          NUM_CH    = 4,
    parameter logic [15:0] K_DEFAULT = 16'd48896,
    parameter logic [15:0] R_DEFAULT = 16'd2030
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   val_ready,
    input  logic [16*NUM_CH-1:0]   cur_cmd,
    input  logic [16*NUM_CH-1:0]   cur_fb,
    input  logic                   coef_wr,
    input  logic                   coef_sel,
    input  logic [2:0]             coef_ch,
    input  logic [15:0]            coef_data,
    output logic                   coef_ack,
    output logic                   emf_busy,
    output logic                   emf_ready,
    output logic [17*NUM_CH-1:0]   emf_out,
    output logic [NUM_CH-1:0]      emf_overflow,
    output logic                   sample_drop
);

    localparam int                c_ch_w     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_ch_w-1:0] c_last_ch  = c_ch_w'(NUM_CH - 1);
    localparam logic [c_ch_w-1:0] c_ch_one   = c_ch_w'(1);
    localparam logic [3:0]        c_num_ch   = 4'(NUM_CH);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_mul_cmd = 3'd1;
    localparam logic [2:0] c_st_mul_fb  = 3'd2;
    localparam logic [2:0] c_st_write   = 3'd3;
    localparam logic [2:0] c_st_done    = 3'd4;

    logic [2:0]             r_state;
    logic [c_ch_w-1:0]      r_ch;
    logic                   r_val_last;
    logic                   r_busy;
    logic                   r_ready;
    logic                   r_ack;
    logic                   r_drop;
    logic [15:0]            r_k;
    logic [16*NUM_CH-1:0]   r_rcoef;
    logic [16*NUM_CH-1:0]   r_cap_cmd;
    logic [16*NUM_CH-1:0]   r_cap_fb;
    logic [31:0]            r_prod;
    logic [15:0]            r_cmd_term;
    logic [17*NUM_CH-1:0]   r_shadow;
    logic [NUM_CH-1:0]      r_shadow_ovf;
    logic [17*NUM_CH-1:0]   r_emf;
    logic [NUM_CH-1:0]      r_ovf;

    logic                   w_rise;
    logic                   w_trig;
    logic                   w_coef_ok;
    logic [15:0]            w_mul_a;
    logic [15:0]            w_mul_b;
    logic [16:0]            w_raw;
    logic [16:0]            w_res;

    assign w_rise    = val_ready & ~r_val_last;
    assign w_trig    = w_rise & ~r_busy;
    // Out-of-range R writes are dropped silently; K writes ignore coef_ch.
    assign w_coef_ok = coef_wr & ~r_busy & ~w_trig
                     & (coef_sel | ({1'b0, coef_ch} < c_num_ch));

    // The single multiplier is steered between the command and feedback terms.
    assign w_mul_a = (r_state == c_st_mul_fb) ? r_cap_fb[r_ch*16 +: 16] : r_cap_cmd[r_ch*16 +: 16];
    assign w_mul_b = (r_state == c_st_mul_fb) ? r_rcoef[r_ch*16 +: 16]  : r_k;

    assign w_raw = {1'b0, r_cmd_term} - {1'b0, r_prod[31:16]};
`ifdef MOTOR_EMF_SAT_EN
    assign w_res = w_raw[16] ? 17'h00000 : w_raw;
`else
    assign w_res = w_raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_ch         <= '0;
            r_val_last   <= 1'b0;
            r_busy       <= 1'b0;
            r_ready      <= 1'b0;
            r_ack        <= 1'b0;
            r_drop       <= 1'b0;
            r_k          <= K_DEFAULT;
            r_rcoef      <= {NUM_CH{R_DEFAULT}};
            r_cap_cmd    <= '0;
            r_cap_fb     <= '0;
            r_prod       <= '0;
            r_cmd_term   <= '0;
            r_shadow     <= '0;
            r_shadow_ovf <= '0;
            r_emf        <= '0;
            r_ovf        <= '0;
        end else begin
            r_val_last <= val_ready;
            // Busy lags the FSM by one cycle so it stays high through DONE.
            r_busy     <= (r_state != c_st_idle);
            r_ready    <= 1'b0;
            r_ack      <= w_coef_ok;
            r_prod     <= {16'b0, w_mul_a} * {16'b0, w_mul_b};

            if (w_rise && r_busy) begin
                r_drop <= 1'b1;
            end

            if (w_coef_ok) begin
                if (coef_sel) begin
                    r_k <= coef_data;
                end else begin
                    r_rcoef[coef_ch*16 +: 16] <= coef_data;
                end
            end

            case (r_state)
                c_st_idle: begin
                    if (w_trig) begin
                        r_cap_cmd <= cur_cmd;
                        r_cap_fb  <= cur_fb;
                        r_ch      <= '0;
                        r_state   <= c_st_mul_cmd;
                    end
                end
                c_st_mul_cmd: begin
                    r_state <= c_st_mul_fb;
                end
                c_st_mul_fb: begin
                    r_cmd_term <= r_prod[31:16];
                    r_state    <= c_st_write;
                end
                c_st_write: begin
                    r_shadow[r_ch*17 +: 17] <= w_res;
                    r_shadow_ovf[r_ch]      <= w_raw[16];
                    if (r_ch == c_last_ch) begin
                        r_state <= c_st_done;
                    end else begin
                        r_ch    <= r_ch + c_ch_one;
                        r_state <= c_st_mul_cmd;
                    end
                end
                c_st_done: begin
                    r_emf   <= r_shadow;
                    r_ovf   <= r_shadow_ovf;
                    r_ready <= 1'b1;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign coef_ack     = r_ack;
    assign emf_busy     = r_busy;
    assign emf_ready    = r_ready;
    assign emf_out      = r_emf;
    assign emf_overflow = r_ovf;
    assign sample_drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_motor_emf_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_motor_emf_multi
// Brief    : Scoreboard bench for motor_emf_multi with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_emf_multi;

    localparam int NUM_CH = 4;
    localparam int K_DEF  = 48896;
    localparam int R_DEF  = 2030;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  val_ready = 1'b0;
    logic [16*NUM_CH-1:0]  cur_cmd = '0;
    logic [16*NUM_CH-1:0]  cur_fb = '0;
    logic                  coef_wr = 1'b0;
    logic                  coef_sel = 1'b0;
    logic [2:0]            coef_ch = 3'd0;
    logic [15:0]           coef_data = 16'd0;
    logic                  coef_ack;
    logic                  emf_busy;
    logic                  emf_ready;
    logic [17*NUM_CH-1:0]  emf_out;
    logic [NUM_CH-1:0]     emf_overflow;
    logic                  sample_drop;

    motor_emf_multi #(.NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset(reset), .val_ready(val_ready),
        .cur_cmd(cur_cmd), .cur_fb(cur_fb),
        .coef_wr(coef_wr), .coef_sel(coef_sel), .coef_ch(coef_ch), .coef_data(coef_data),
        .coef_ack(coef_ack), .emf_busy(emf_busy), .emf_ready(emf_ready),
        .emf_out(emf_out), .emf_overflow(emf_overflow), .sample_drop(sample_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int m_k;
    int m_r [NUM_CH];
    int last_trig;

    typedef struct {
        logic [17*NUM_CH-1:0] emf;
        logic [NUM_CH-1:0]    ovf;
        int                   due;
    } exp_t;
    exp_t sb [$];
    exp_t mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: each channel's bemf from the Q-format arithmetic directly.
    function automatic void model(input logic [16*NUM_CH-1:0] cmd, input logic [16*NUM_CH-1:0] fb,
                                  output logic [17*NUM_CH-1:0] emf, output logic [NUM_CH-1:0] ovf);
        longint ct, ft, raw;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            ct  = (longint'(cmd[16*ch +: 16]) * longint'(m_k)) / 65536;
            ft  = (longint'(fb[16*ch +: 16]) * longint'(m_r[ch])) / 65536;
            raw = ct - ft;
            ovf[ch] = (raw < 0);
`ifdef MOTOR_EMF_SAT_EN
            if (raw < 0) raw = 0;
`endif
            emf[17*ch +: 17] = 17'(raw);
        end
    endfunction

    function automatic void model_reset();
        m_k = K_DEF;
        for (int ch = 0; ch < NUM_CH; ch++) m_r[ch] = R_DEF;
    endfunction

    function automatic logic [16*NUM_CH-1:0] rand_vec();
        logic [16*NUM_CH-1:0] v;
        for (int ch = 0; ch < NUM_CH; ch++) v[16*ch +: 16] = 16'($urandom_range(0, 65535));
        return v;
    endfunction

    always @(negedge clk) begin
        if (emf_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_emf_ready", 128'd1, 128'd0);
            end else begin
                mon_e = sb.pop_front();
                check("emf_out", 128'(emf_out), 128'(mon_e.emf));
                check("emf_overflow", 128'(emf_overflow), 128'(mon_e.ovf));
                check("emf_ready_cycle", 128'(cyc), 128'(mon_e.due));
            end
        end
    end

    // Called at a negedge; returns one cycle later with val_ready low.
    task automatic trigger(input logic [16*NUM_CH-1:0] cmd, input logic [16*NUM_CH-1:0] fb);
        exp_t e;
        cur_cmd   = cmd;
        cur_fb    = fb;
        val_ready = 1'b1;
        model(cmd, fb, e.emf, e.ovf);
        last_trig = cyc;
        e.due     = cyc + 14;
        sb.push_back(e);
        @(negedge clk);
        val_ready = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < last_trig + 14) @(negedge clk);
        check("busy_in_done", 128'(emf_busy), 128'd1);
        @(negedge clk);
        check("busy_released", 128'(emf_busy), 128'd0);
        check("ready_seen", 128'(sb.size()), 128'd0);
    endtask

    task automatic coef_write(input logic sel, input logic [2:0] ch, input logic [15:0] data,
                              input logic exp_ack);
        coef_wr   = 1'b1;
        coef_sel  = sel;
        coef_ch   = ch;
        coef_data = data;
        @(negedge clk);
        coef_wr = 1'b0;
        check("coef_ack", 128'(coef_ack), 128'(exp_ack));
        if (exp_ack) begin
            if (sel) m_k = int'(data);
            else     m_r[ch] = int'(data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*NUM_CH-1:0] v;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_emf_out", 128'(emf_out), 128'd0);
        check("rst_overflow", 128'(emf_overflow), 128'd0);
        check("rst_busy_ready", 128'({emf_busy, emf_ready, coef_ack, sample_drop}), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed operating points.
        v = rand_vec(); v[15:0] = 16'h8000;
        trigger(v, {rand_vec() >> 16, 16'h8000});
        wait_idle();
        trigger({NUM_CH{16'hFFFF}}, {NUM_CH{16'hFFFF}});
        wait_idle();
        trigger('0, {NUM_CH{16'h8000}});
        wait_idle();

        // R[2] = 1.0 ohm, then an invalid-channel write, then K update.
        coef_write(1'b0, 3'd2, 16'h0100, 1'b1);
        trigger('0, {NUM_CH{16'h8000}});
        wait_idle();
        coef_write(1'b0, 3'd5, 16'h1234, 1'b0);
        trigger('0, {NUM_CH{16'h8000}});
        // Writes while the conversion runs must be ignored.
        @(negedge clk);
        coef_write(1'b0, 3'd2, 16'h0500, 1'b0);
        coef_write(1'b1, 3'd0, 16'h0001, 1'b0);
        wait_idle();
        trigger(rand_vec(), rand_vec());
        wait_idle();

        // Randomized back-to-back conversions at the minimum retrigger spacing.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0)
                coef_write($urandom_range(0, 1) == 1, 3'($urandom_range(0, NUM_CH - 1)),
                           16'($urandom_range(0, 65535)), 1'b1);
            trigger(rand_vec(), rand_vec());
            wait_idle();
        end
        check("no_drop_yet", 128'(sample_drop), 128'd0);

        // Input change after capture plus a held-high second edge while busy.
        trigger(rand_vec(), rand_vec());
        @(negedge clk);
        cur_cmd = rand_vec();
        cur_fb  = rand_vec();
        while (cyc < last_trig + 5) @(negedge clk);
        val_ready = 1'b1;
        wait_idle();
        check("sample_drop_set", 128'(sample_drop), 128'd1);
        val_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in mid-conversion aborts and restores defaults.
        trigger(rand_vec(), rand_vec());
        while (cyc < last_trig + 6) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        check("midrst_emf_out", 128'(emf_out), 128'd0);
        check("midrst_flags", 128'({emf_busy, emf_ready, sample_drop, emf_overflow}), 128'd0);
        reset = 1'b0;
        model_reset();
        repeat (12) @(negedge clk);
        trigger({NUM_CH{16'h8000}}, {NUM_CH{16'h8000}});
        wait_idle();
        trigger('0, {NUM_CH{16'h8000}});
        wait_idle();

        check("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_emf_multi.md
# motor_emf_multi

Multi-channel, parametrised back-EMF estimator for the QLA motor channels. On each ADC sample strobe it captures all channels' commanded and measured currents. It then evaluates bemf = K·cur_cmd − R·cur_fb per channel through one shared, time-multiplexed multiplier, and presents all results atomically. K (board gain × DAC gain × 2) and the per-channel resistances R are runtime-programmable. It sits between the ADC/DAC current path and the status/readback logic.

## Interface
- NUM_CH, 4: number of motor channels, 1–8.
- K_DEFAULT, 48896: reset value of K in Q8.8 (2·38.2·2.5 = 191.0).
- R_DEFAULT, 2030: reset value of every R in Q8.8 (7.93 Ω).
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- val_ready  in  1  ADC sample strobe; a conversion starts on its rising edge.
- cur_cmd  in  16·NUM_CH  commanded current per channel, unsigned Q0.16; channel n is at [16n+15:16n].
- cur_fb  in  16·NUM_CH  measured current per channel, unsigned Q0.16.
- coef_wr  in  1  coefficient write strobe.
- coef_sel  in  1  0 selects R[coef_ch]; 1 selects K (coef_ch ignored).
- coef_ch  in  3  channel index for an R write.
- coef_data  in  16  coefficient value, Q8.8.
- coef_ack  out  1  one-cycle pulse when a write is accepted.
- emf_busy  out  1  high while a conversion is in progress.
- emf_ready  out  1  one-cycle pulse when emf_out/emf_overflow update.
- emf_out  out  17·NUM_CH  per-channel bemf, 17-bit two's complement Q9.8.
- emf_overflow  out  NUM_CH  per-channel flag: raw result was negative.
- sample_drop  out  1  sticky flag: a rising edge arrived while busy.

## Operation
- Edge detect:
  - val_ready_last is registered every cycle.
  - trig = val_ready & ~val_ready_last & ~emf_busy.
  - A rising edge while busy sets sample_drop and is otherwise ignored.
- On trig, all cur_cmd/cur_fb words are captured into internal registers. Input changes after that edge do not affect the conversion.
- FSM states: IDLE → per channel {MUL_CMD → MUL_FB → WRITE} for ch = 0..NUM_CH−1 → DONE → IDLE.
  - MUL_CMD: cmd_term = (cap_cmd[ch]·K)[31:16], unsigned 16 b.
  - MUL_FB: fb_term = (cap_fb[ch]·R[ch])[31:16].
  - WRITE: raw = {1'b0,cmd_term} − {1'b0,fb_term}, 17 b. raw[16] goes to the shadow overflow bit; the result goes to shadow[ch].
  - DONE: all shadows transfer to emf_out/emf_overflow; emf_ready pulses; emf_busy drops.
- The shared multiplier is 16×16 → 32, one product per cycle, registered.
- Coefficient write:
  - Accepted only when emf_busy=0 and trig=0 in that cycle. Applied on the next edge; coef_ack pulses the same cycle as the update.
  - A write while busy, coincident with trig, or with coef_ch ≥ NUM_CH is dropped with no ack.
- Reset values:
  - All outputs are 0.
  - State is IDLE; val_ready_last is 0.
  - K = K_DEFAULT; all R = R_DEFAULT; sample_drop = 0.
- Reset mid-conversion aborts the conversion. No emf_ready pulse, and outputs return to 0.

## Timing
- Let E be the clock edge at which trig is sampled high.
- emf_busy is high from E+1 through the DONE cycle.
- emf_ready is high exactly at cycle E+3·NUM_CH+1 (13 for NUM_CH=4). Outputs change only at that cycle.
- Minimum retrigger: the next rising edge is honoured if it arrives at or after the first cycle with emf_busy=0.
- val_ready held high does not retrigger; it must fall and rise again.
- emf_out holds its value between emf_ready pulses.

## Configuration
- MOTOR_EMF_SAT_EN defined: a negative raw result is clamped to 17'h00000 in emf_out, and emf_overflow is still set.
- Not defined: raw two's complement is emitted unchanged, and emf_overflow = raw[16].

## Test plan
- Defaults, cur_cmd=0x8000, cur_fb=0x8000 on ch0, rising val_ready → emf_ready at E+13; ch0 emf_out = 24448−1015 = 23433 (0x05B89), overflow 0.
- cur_cmd=0xFFFF, cur_fb=0xFFFF → 48895−2029 = 46866 (0x0B712).
- cur_cmd=0, cur_fb=0x8000 → overflow=1; emf_out=0x1FC09 without the macro, 0x00000 with it.
- Write R[2]=0x0100 (1.0 Ω) while idle → coef_ack pulses. Then cmd=0, fb=0x8000 on ch2 → raw −128 (0x1FF80 without the macro). Repeat the write while busy → no ack, value unchanged.
- Second rising edge at E+5 → sample_drop=1, a single emf_ready. Change inputs at E+2 → results reflect the captured values.
- Assert reset at E+6 → no emf_ready; outputs, K and R at reset values; a new trigger converts normally.
